pingpong_buffer_reader: RTL

// - Read-side drain engine for the ping-pong (double) buffer: consumes banks filled by the writer side.
// - Waits for the current bank to be marked full, streams DEPTH words out on a valid/ready interface,

---
 rtl/pingpong_buffer_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pingpong_buffer_reader.sv
// Ping-pong bank drain engine: streams banks 0,1,0,1,... onto a valid/ready port.
// Define PINGPONG_RD_STATS_EN to add the stat_banks / stat_stalls counters.
module pingpong_buffer_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bank_full,
    output logic [1:0]        bank_release,
    output logic              mem_rd_en,
    output logic              mem_rd_bank,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
`ifdef PINGPONG_RD_STATS_EN
    input  logic              m_ready,
    output logic [31:0]       stat_banks,
    output logic [31:0]       stat_stalls
`else
    input  logic              m_ready
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_RELEASE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              cur_bank;
    logic [ADDR_W-1:0] cnt;
    logic              in_flight;
    logic              in_flight_last;
    logic              sk_valid;
    logic [DATA_W-1:0] sk_data;
    logic              sk_last;
    logic              pop;
    logic              push;
    logic [1:0]        occ;
    logic              can_issue;
    logic              last_addr;

    assign pop  = m_valid & m_ready;
    assign push = in_flight;

    // occupancy seen by the credit check: a same-cycle pop frees a slot
    assign occ = {1'b0, m_valid} + {1'b0, sk_valid}
               + {1'b0, in_flight} - {1'b0, pop};

    assign can_issue = (occ < 2'd2);
    assign last_addr = (cnt == LAST);

    assign mem_rd_bank = cur_bank;
    assign mem_rd_addr = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        mem_rd_en    = 1'b0;
        bank_release = 2'b00;
        case (state)
            S_IDLE: begin
                if (bank_full[cur_bank]) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mem_rd_en = can_issue;
                if (can_issue && last_addr) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!in_flight) begin
                    state_nx = S_RELEASE;
                end
            end
            S_RELEASE: begin
                bank_release = cur_bank ? 2'b10 : 2'b01;
                state_nx     = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_bank <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == S_IDLE && state_nx == S_DRAIN) begin
                cnt <= '0;
            end else if (mem_rd_en) begin
                cnt <= last_addr ? '0 : cnt + ADDR_W'(1);
            end
            if (state == S_RELEASE) begin
                cur_bank <= ~cur_bank;
            end
        end
    end

    // BRAM returns data one cycle after the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= mem_rd_en;
            in_flight_last <= mem_rd_en & last_addr;
        end
    end

    // two-entry FWFT FIFO: head drives m_* directly, skid holds the second
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
            sk_last  <= 1'b0;
        end else if (pop) begin
            if (sk_valid) begin
                m_data <= sk_data;
                m_last <= sk_last;
                if (push) begin
                    sk_data <= mem_rd_data;
                    sk_last <= in_flight_last;
                end else begin
                    sk_valid <= 1'b0;
                end
            end else if (push) begin
                m_data <= mem_rd_data;
                m_last <= in_flight_last;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (push) begin
            if (!m_valid) begin
                m_valid <= 1'b1;
                m_data  <= mem_rd_data;
                m_last  <= in_flight_last;
            end else begin
                sk_valid <= 1'b1;
                sk_data  <= mem_rd_data;
                sk_last  <= in_flight_last;
            end
        end
    end

`ifdef PINGPONG_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_banks  <= '0;
            stat_stalls <= '0;
        end else begin
            if (bank_release != 2'b00 && stat_banks != 32'hFFFF_FFFF) begin
                stat_banks <= stat_banks + 32'd1;
            end
            if (m_valid && !m_ready && stat_stalls != 32'hFFFF_FFFF) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`else
    // no statistics counters in this build
`endif

endmodule
